// File: rtl/pac_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pac_move_ctrl
// Brief    : Pacman movement initiator. On each move_tick it probes the
//            collision responder (turn first if a new direction is pending,
//            then forward). It then commits one STEP-pixel move and updates the
//            facing direction.
// Options  : define TUNNEL_WRAP_EN to enable the side-tunnel wrap on row
//            TUNNEL_Y (x == TUNNEL_L <-> x == TUNNEL_R).
// Revision : 1.0 - initial release
// ============================================================================
module pac_move_ctrl #(
    parameter int STEP     = 8,
    parameter int START_X  = 312,
    parameter int START_Y  = 344,
    parameter int TIMEOUT  = 15
`ifdef TUNNEL_WRAP_EN
    ,
    parameter int TUNNEL_Y = 232,
    parameter int TUNNEL_L = 0,
    parameter int TUNNEL_R = 632
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic       key_valid,
    input  logic [1:0] key_dir,
    output logic       probe_valid,
    output logic [9:0] probe_x,
    output logic [8:0] probe_y,
    output logic [1:0] probe_dir,
    input  logic       probe_done,
    input  logic       probe_ok,
    output logic [9:0] pac_x,
    output logic [8:0] pac_y,
    output logic [1:0] pac_dir,
    output logic       moved,
    output logic       blocked,
    output logic       overrun,
    output logic       busy
);

    localparam logic [9:0] c_step_x       = 10'(STEP);
    localparam logic [8:0] c_step_y       = 9'(STEP);
    localparam logic [9:0] c_start_x      = 10'(START_X);
    localparam logic [8:0] c_start_y      = 9'(START_Y);
    localparam logic [3:0] c_timeout_last = 4'(TIMEOUT - 1);
    localparam logic [1:0] c_dir_up       = 2'b00;
    localparam logic [1:0] c_dir_down     = 2'b01;
    localparam logic [1:0] c_dir_left     = 2'b10;
`ifdef TUNNEL_WRAP_EN
    localparam logic [1:0] c_dir_right    = 2'b11;
    localparam logic [8:0] c_tunnel_y     = 9'(TUNNEL_Y);
    localparam logic [9:0] c_tunnel_l     = 10'(TUNNEL_L);
    localparam logic [9:0] c_tunnel_r     = 10'(TUNNEL_R);
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ_TURN = 2'd1,
        S_REQ_FWD  = 2'd2,
        S_COMMIT   = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_pend_dir;
    logic       r_pend_valid;
    logic [3:0] r_cnt;

    logic [9:0] w_next_x;
    logic [8:0] w_next_y;
    logic       w_timeout;

    // The probe always asks about the cell adjacent to the committed position.
    assign probe_x   = pac_x;
    assign probe_y   = pac_y;

    // The wait counter holds TIMEOUT-1 during the last cycle a request may stay up.
    assign w_timeout = (r_cnt == c_timeout_last);

    // Position one step ahead in the facing direction (wraps naturally).
    always_comb begin
        w_next_x = pac_x;
        w_next_y = pac_y;
        case (pac_dir)
            c_dir_up:   w_next_y = pac_y - c_step_y;
            c_dir_down: w_next_y = pac_y + c_step_y;
            c_dir_left: w_next_x = pac_x - c_step_x;
            default:    w_next_x = pac_x + c_step_x;
        endcase
`ifdef TUNNEL_WRAP_EN
        if (pac_y == c_tunnel_y) begin
            if ((pac_dir == c_dir_left) && (pac_x == c_tunnel_l)) begin
                w_next_x = c_tunnel_r;
            end else if ((pac_dir == c_dir_right) && (pac_x == c_tunnel_r)) begin
                w_next_x = c_tunnel_l;
            end
        end
`endif
    end

    // Movement FSM, pending-direction latch and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pend_valid <= 1'b0;
            r_pend_dir   <= 2'b00;
            r_cnt        <= 4'd0;
            pac_x        <= c_start_x;
            pac_y        <= c_start_y;
            pac_dir      <= c_dir_left;
            probe_valid  <= 1'b0;
            probe_dir    <= c_dir_left;
            moved        <= 1'b0;
            blocked      <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
            overrun <= move_tick && (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (move_tick) begin
                        busy        <= 1'b1;
                        probe_valid <= 1'b1;
                        r_cnt       <= 4'd0;
                        if (r_pend_valid && (r_pend_dir != pac_dir)) begin
                            r_state   <= S_REQ_TURN;
                            probe_dir <= r_pend_dir;
                        end else begin
                            // A pending key equal to the facing is simply consumed.
                            r_state      <= S_REQ_FWD;
                            probe_dir    <= pac_dir;
                            r_pend_valid <= 1'b0;
                        end
                    end
                end

                S_REQ_TURN: begin
                    // probe_dir holds the turn direction latched at request time.
                    if (probe_done) begin
                        probe_valid <= 1'b0;
                        if (probe_ok) begin
                            pac_dir      <= probe_dir;
                            r_pend_valid <= 1'b0;
                            r_state      <= S_COMMIT;
                        end else begin
                            r_state <= S_REQ_FWD;
                        end
                    end else if (w_timeout) begin
                        probe_valid <= 1'b0;
                        r_state     <= S_REQ_FWD;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                S_REQ_FWD: begin
                    if (!probe_valid) begin
                        // Gap cycle after a failed turn: raise a fresh request.
                        probe_valid <= 1'b1;
                        probe_dir   <= pac_dir;
                        r_cnt       <= 4'd0;
                    end else if (probe_done) begin
                        probe_valid <= 1'b0;
                        if (probe_ok) begin
                            r_state <= S_COMMIT;
                        end else begin
                            blocked <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        probe_valid <= 1'b0;
                        blocked     <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                S_COMMIT: begin
                    pac_x   <= w_next_x;
                    pac_y   <= w_next_y;
                    moved   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            // A fresh key always wins over the FSM consuming the pending direction.
            if (key_valid) begin
                r_pend_dir   <= key_dir;
                r_pend_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pac_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pac_move_ctrl
// Brief    : Self-checking bench for pac_move_ctrl: directed scenarios with
//            literal expectations, then randomized ticks/keys/responder checked
//            every cycle against a sequential behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pac_move_ctrl;

    localparam int STEP    = 8;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       move_tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_dir = 2'b00;
    logic       probe_valid;
    logic [9:0] probe_x;
    logic [8:0] probe_y;
    logic [1:0] probe_dir;
    logic       probe_done = 1'b0;
    logic       probe_ok = 1'b0;
    logic [9:0] pac_x;
    logic [8:0] pac_y;
    logic [1:0] pac_dir;
    logic       moved;
    logic       blocked;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    pac_move_ctrl dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .key_valid(key_valid),
        .key_dir(key_dir), .probe_valid(probe_valid), .probe_x(probe_x),
        .probe_y(probe_y), .probe_dir(probe_dir), .probe_done(probe_done),
        .probe_ok(probe_ok), .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir),
        .moved(moved), .blocked(blocked), .overrun(overrun), .busy(busy)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- responder ----------------
    bit rsp_rand = 1'b0;
    int q_rsp[$];
    bit rsp_active = 1'b0, rsp_given = 1'b0, rsp_ok = 1'b0, rsp_never = 1'b0;
    int rsp_cnt = 0, rsp_lat = 0;

    task automatic push_rsp(input int lat, input bit ok, input bit never);
        q_rsp.push_back(lat | (int'(ok) << 4) | (int'(never) << 5));
    endtask

    always @(negedge clk) begin
        if (probe_valid === 1'b1 && !rsp_given) begin
            if (!rsp_active) begin
                int ent;
                rsp_active = 1'b1;
                rsp_cnt = 0;
                if (rsp_rand) begin
                    rsp_lat   = $urandom_range(0, 3);
                    rsp_ok    = ($urandom_range(0, 3) != 0);
                    rsp_never = ($urandom_range(0, 9) == 0);
                end else begin
                    ent = (q_rsp.size() > 0) ? q_rsp.pop_front() : (1 | (1 << 4));
                    rsp_lat   = ent & 15;
                    rsp_ok    = ent[4];
                    rsp_never = ent[5];
                end
            end
            if (!rsp_never && rsp_cnt == rsp_lat) begin
                probe_done = 1'b1;
                probe_ok   = rsp_ok;
                rsp_given  = 1'b1;
            end else begin
                probe_done = 1'b0;
                probe_ok   = 1'($urandom_range(0, 1));
                rsp_cnt++;
            end
        end else begin
            probe_done = 1'b0;
            if (probe_valid !== 1'b1) begin
                rsp_active = 1'b0;
                rsp_given  = 1'b0;
                if (rsp_rand && $urandom_range(0, 19) == 0) begin
                    probe_done = 1'b1;
                    probe_ok   = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // ---------------- behavioural model ----------------
    bit m_run = 1'b0, chk_en = 1'b0;
    bit m_pv = 1'b0;
    int m_pd = 0;
    bit s_tick, s_key, s_done, s_ok;
    int s_kd;
    bit e_pv = 1'b0, e_busy = 1'b0, e_moved = 1'b0, e_blocked = 1'b0, e_overrun = 1'b0;
    int e_x = 312, e_y = 344, e_dir = 2, e_pdir = 2;

    task automatic m_step(input bit bsy);
        @(posedge clk);
        s_tick = move_tick; s_key = key_valid; s_kd = int'(key_dir);
        s_done = probe_done; s_ok = probe_ok;
        e_moved = 1'b0; e_blocked = 1'b0;
        e_overrun = bsy && s_tick;
    endtask

    task automatic m_take_key();
        if (s_key) begin
            m_pv = 1'b1;
            m_pd = s_kd;
        end
    endtask

    // One request: up to TIMEOUT cycles of waiting; ok=1 only on done&ok.
    task automatic m_probe(output bit ok);
        int n;
        n = 0;
        forever begin
            m_step(1'b1);
            if (s_done) begin
                e_pv = 1'b0; ok = s_ok; return;
            end
            n++;
            if (n == TIMEOUT) begin
                e_pv = 1'b0; ok = 1'b0; return;
            end
            m_take_key();
        end
    endtask

    task automatic m_commit();
        bit wrapped;
        m_step(1'b1);
        m_take_key();
        wrapped = 1'b0;
`ifdef TUNNEL_WRAP_EN
        if (e_y == 232 && e_dir == 2 && e_x == 0) begin e_x = 632; wrapped = 1'b1; end
        else if (e_y == 232 && e_dir == 3 && e_x == 632) begin e_x = 0; wrapped = 1'b1; end
`endif
        if (!wrapped) begin
            case (e_dir)
                0: e_y = (e_y - STEP + 512) % 512;
                1: e_y = (e_y + STEP) % 512;
                2: e_x = (e_x - STEP + 1024) % 1024;
                default: e_x = (e_x + STEP) % 1024;
            endcase
        end
        e_moved = 1'b1;
        e_busy  = 1'b0;
    endtask

    initial begin : model
        int tdir;
        bit ok;
        wait (m_run);
        forever begin
            m_step(1'b0);
            if (!s_tick) begin
                m_take_key();
                continue;
            end
            e_busy = 1'b1;
            if (m_pv && m_pd != e_dir) begin
                tdir = m_pd;
                e_pv = 1'b1; e_pdir = tdir;
                m_take_key();
                m_probe(ok);
                if (ok) begin
                    e_dir = tdir; m_pv = 1'b0;
                    m_take_key();
                    m_commit();
                    continue;
                end
                m_take_key();
                m_step(1'b1);
                m_take_key();
            end else begin
                m_pv = 1'b0;
                m_take_key();
            end
            e_pv = 1'b1; e_pdir = e_dir;
            m_probe(ok);
            if (ok) begin
                m_take_key();
                m_commit();
            end else begin
                e_blocked = 1'b1; e_busy = 1'b0;
                m_take_key();
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("probe_valid", probe_valid, e_pv);
            chk("busy", busy, e_busy);
            chk("pac_x", pac_x, e_x);
            chk("pac_y", pac_y, e_y);
            chk("pac_dir", pac_dir, e_dir);
            chk("moved", moved, e_moved);
            chk("blocked", blocked, e_blocked);
            chk("overrun", overrun, e_overrun);
            if (e_pv) begin
                chk("probe_dir", probe_dir, e_pdir);
                chk("probe_x", probe_x, e_x);
                chk("probe_y", probe_y, e_y);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        move_tick = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic press(input int d);
        cyc();
        key_valid = 1'b1;
        key_dir = 2'(d);
    endtask

    int d_pulses, d_dir0, d_dir1, d_px0, d_py0, d_pvhi, d_lat;
    bit d_moved, d_blocked, d_overrun, d_busy_end;

    task automatic do_move(input bit second_tick);
        bit prev_pv, fin;
        prev_pv = 1'b0; fin = 1'b0;
        d_pulses = 0; d_dir0 = -1; d_dir1 = -1; d_px0 = -1; d_py0 = -1;
        d_pvhi = 0; d_lat = -1;
        d_moved = 1'b0; d_blocked = 1'b0; d_overrun = 1'b0; d_busy_end = 1'b1;
        cyc();
        move_tick = 1'b1;
        for (int n = 1; n <= 80 && !fin; n++) begin
            cyc();
            if (second_tick && n == 1) move_tick = 1'b1;
            if (probe_valid) d_pvhi++;
            if (probe_valid && !prev_pv) begin
                if (d_pulses == 0) begin
                    d_dir0 = int'(probe_dir); d_px0 = int'(probe_x); d_py0 = int'(probe_y);
                end else begin
                    d_dir1 = int'(probe_dir);
                end
                d_pulses++;
            end
            prev_pv = probe_valid;
            if (overrun) d_overrun = 1'b1;
            if (moved) begin d_moved = 1'b1; d_lat = n; end
            if (blocked) d_blocked = 1'b1;
            if (moved || blocked) begin fin = 1'b1; d_busy_end = busy; end
        end
        chk("move_completes", fin, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_pac_x", pac_x, 312);
        chk("rst_pac_y", pac_y, 344);
        chk("rst_pac_dir", pac_dir, 2);
        chk("rst_probe_valid", probe_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {moved, blocked, overrun}, 0);
        rst = 1'b0;
        m_run = 1'b1;
        chk_en = 1'b1;

        // Single forward step, responder answers after 2 waiting cycles.
        push_rsp(2, 1, 0);
        do_move(1'b0);
        chk("t1_pulses", d_pulses, 1);
        chk("t1_probe_dir", d_dir0, 2);
        chk("t1_probe_xy", {d_px0[15:0], d_py0[15:0]}, {16'd312, 16'd344});
        chk("t1_latency", d_lat, 5);
        chk("t1_pac_x", pac_x, 304);
        chk("t1_pac_y", pac_y, 344);
        chk("t1_model_x", e_x, 304);

        // Turn up refused, forward accepted: two separate requests.
        push_rsp(0, 0, 0);
        push_rsp(0, 1, 0);
        press(0);
        do_move(1'b0);
        chk("t3_pulses", d_pulses, 2);
        chk("t3_dir0", d_dir0, 0);
        chk("t3_dir1", d_dir1, 2);
        chk("t3_pac_x", pac_x, 296);
        chk("t3_pac_dir", pac_dir, 2);

        // Retained turn is retried and accepted.
        push_rsp(0, 1, 0);
        do_move(1'b0);
        chk("t2_pulses", d_pulses, 1);
        chk("t2_dir0", d_dir0, 0);
        chk("t2_pac_dir", pac_dir, 0);
        chk("t2_pac_y", pac_y, 336);
        chk("t2_latency", d_lat, 3);
        chk("t2_model_y", e_y, 336);

        // Pending turn was cleared: plain forward step.
        push_rsp(0, 1, 0);
        do_move(1'b0);
        chk("t2b_pulses", d_pulses, 1);
        chk("t2b_pac_y", pac_y, 328);

        // No response at all: timeout, blocked.
        push_rsp(0, 0, 1);
        do_move(1'b0);
        chk("t4_pv_cycles", d_pvhi, TIMEOUT);
        chk("t4_blocked", d_blocked, 1);
        chk("t4_moved", d_moved, 0);
        chk("t4_busy_end", d_busy_end, 0);
        chk("t4_pos", {pac_x, pac_y}, {10'd296, 9'd328});

        // Tick while busy: overrun and only one step.
        push_rsp(3, 1, 0);
        do_move(1'b1);
        chk("t5_overrun", d_overrun, 1);
        chk("t5_pulses", d_pulses, 1);
        chk("t5_pac_y", pac_y, 320);

        // Walk to the tunnel row entrance at (0,232).
        for (int i = 0; i < 11; i++) do_move(1'b0);
        chk("nav_pac_y", pac_y, 232);
        press(2);
        for (int i = 0; i < 37; i++) do_move(1'b0);
        chk("nav_pac_x", pac_x, 0);
        chk("nav_pac_dir", pac_dir, 2);
        do_move(1'b0);
`ifdef TUNNEL_WRAP_EN
        chk("t6_wrap_x", pac_x, 632);
`else
        chk("t6_wrap_x", pac_x, 1016);
`endif

        // Randomized ticks, keys and responder behaviour.
        rsp_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            move_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                key_valid = 1'b1;
                key_dir = 2'($urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 100 && busy; i++) cyc();
        chk("drain_idle", busy, 0);

        // Reset in the middle of a forward request.
        rsp_rand = 1'b0;
        q_rsp.delete();
        push_rsp(0, 0, 1);
        cyc();
        chk_en = 1'b0;
        move_tick = 1'b1;
        for (int i = 0; i < 10 && !probe_valid; i++) cyc();
        repeat (3) cyc();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_probe_valid", probe_valid, 0);
        chk("mid_rst_pos", {pac_x, pac_y}, {10'd312, 9'd344});
        chk("mid_rst_dir", pac_dir, 2);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        do_move(1'b0);
        chk("post_rst_pac_x", pac_x, 304);
        chk("post_rst_dir0", d_dir0, 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
